// File: rtl/exp_neg_iter.sv
// exp_neg_iter: iterative y = e^-x for an unsigned fixed-point x.
//
// The design processes one bit of x per clock, from the MSB down to the LSB. For every set bit
// it applies the matching constant factor e^-(2^(k-FRAC_W)) through a single shared
// OUT_W x OUT_W multiplier. The first factor is loaded directly and is not multiplied.
// Later factors are multiplied in, keeping only the upper OUT_W bits.
//
// Ports
//   clock_i          rising-edge clock
//   reset_n_i        asynchronous active-low reset
//   data_i           x, unsigned, FRAC_W fractional bits
//   FP_2_FXP_done_i  input valid (sampled only while ready_o is high)
//   ready_o          input ready, high only while idle
//   data_o           e^-x, unsigned Q0.OUT_W, registered
//   output_valid_o   result valid, held until ready_i accepts it
//   ready_i          downstream ready

module exp_neg_iter #(
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned INT_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              FP_2_FXP_done_i,
  output logic              ready_o,
  output logic [OUT_W-1:0]  data_o,
  output logic              output_valid_o,
  input  logic              ready_i
);

  localparam int unsigned N  = FRAC_W + INT_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  // Working precision for the elaboration-time table.
  // The precision is far above OUT_W, so the final floor is exact for any legal OUT_W.
  localparam int unsigned P  = 112;
  localparam int unsigned CW = 256;

  // Returns floor(e^-(2^(k-FRAC_W)) * 2^OUT_W).
  // For exponents <= 1, the function sums the Taylor series directly. In that range the terms
  // shrink monotonically, so the alternating sum stays non-negative.
  // For larger powers of two, the function repeatedly squares e^-1.
  function automatic logic [OUT_W-1:0] exp_neg_entry(input int unsigned k);
    logic [CW-1:0] one;
    logic [CW-1:0] y;
    logic [CW-1:0] term;
    logic [CW-1:0] sum;
    int unsigned   sq;
    one = CW'(1) << P;
    if (k < FRAC_W) begin
      y  = one >> (FRAC_W - k);
      sq = 0;
    end else begin
      y  = one;
      sq = k - FRAC_W;
    end
    sum  = one;
    term = one;
    for (int unsigned i = 1; i <= 48; i++) begin
      term = ((term * y) >> P) / CW'(i);
      if ((i % 2) == 1) sum = sum - term;
      else              sum = sum + term;
    end
    for (int unsigned j = 0; j < sq; j++) begin
      sum = (sum * sum) >> P;
    end
    return OUT_W'(sum >> (P - OUT_W));
  endfunction

  // Constant factor table, one entry per input bit.
  logic [OUT_W-1:0] lut [N];
  for (genvar g = 0; g < N; g++) begin : gen_lut
    localparam logic [OUT_W-1:0] Entry = exp_neg_entry(g);
    assign lut[g] = Entry;
  end

  // Any set bit at or above 2^INT_W drives the result to zero.
  logic sat_in;
  if (DATA_W > N) begin : gen_sat
    assign sat_in = |data_i[DATA_W-1:N];
  end else begin : gen_nosat
    assign sat_in = 1'b0;
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     x_q, x_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic             first_q, first_d;
  logic [OUT_W-1:0] data_q, data_d;

  logic [OUT_W-1:0] lut_k;
  logic [OUT_W-1:0] mul_hi;

  assign lut_k  = lut[k_q];
  // Truncating multiply: keep the upper half of the 2*OUT_W-bit product.
  assign mul_hi = OUT_W'(({{OUT_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, lut_k}) >> OUT_W);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    k_d     = k_q;
    first_d = first_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (FP_2_FXP_done_i) begin
          x_d = data_i[N-1:0];
          if (data_i == '0) begin
            acc_d   = '1;
            data_d  = '1;
            state_d = StDone;
          end else if (sat_in) begin
            acc_d   = '0;
            data_d  = '0;
            state_d = StDone;
          end else begin
            acc_d   = '1;
            first_d = 1'b1;
            k_d     = KW'(N - 1);
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        if (x_q[k_q]) begin
          if (first_q) begin
            acc_d   = lut_k;
            first_d = 1'b0;
          end else begin
            acc_d   = mul_hi;
          end
        end
        if (k_q == '0) begin
          data_d  = acc_d;
          state_d = StDone;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      first_q <= first_d;
      data_q  <= data_d;
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign output_valid_o = (state_q == StDone);
  assign data_o         = data_q;

endmodule
